// File: rtl/mc_traffic_gen.sv
// mc_traffic_gen: strided write / read-back traffic generator and checker for
// the mc_top 128-bit request port. At most MAX_OUTSTANDING requests are in
// flight at once. Read data is compared in ack order against address-derived data.
module mc_traffic_gen #(
  parameter int          ADDR_W          = 32,
  parameter int          DATA_W          = 128,
  parameter int          CNT_W           = 16,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [31:0] SEED            = 32'hA5A5_0F0F
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic [1:0]          mode_i,
  input  logic                invert_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic [ADDR_W-1:0]   stride_i,
  input  logic [CNT_W-1:0]    count_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [CNT_W-1:0]    err_cnt_o,
  output logic [ADDR_W-1:0]   first_err_addr_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_rd_o,
  output logic [DATA_W/8-1:0] mem_wr_o,
  output logic [DATA_W-1:0]   mem_wrdata_o,
  input  logic                mem_accept_i,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rddata_i
);

  localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int FIFO_D = 2 ** PTR_W;
  localparam int OCNT_W = PTR_W + 1;
  localparam logic [OCNT_W-1:0] MAX_O = OCNT_W'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_DRAIN, S_RD, S_RD_DRAIN, S_DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_mode;
  logic                r_inv;
  logic [ADDR_W-1:0]   r_base, r_stride, r_addr, r_first;
  logic [CNT_W-1:0]    r_count, r_issued, r_err;
  logic [OCNT_W-1:0]   r_outst;
  logic [PTR_W-1:0]    r_wptr, r_rptr;
  logic [ADDR_W-1:0]   r_fifo [0:FIFO_D-1];
  logic                r_pass;

  logic                w_start, w_active, w_req, w_acc, w_last;
  logic                w_ack, w_stray, w_pop, w_mis;
  logic [ADDR_W-1:0]   w_pop_addr, w_first_nxt;
  logic [CNT_W-1:0]    w_err_nxt;

  // Each 32-bit lane is (addr ^ SEED) + lane index, optionally inverted
  function automatic logic [DATA_W-1:0] gen_data(input logic [ADDR_W-1:0] a,
                                                 input logic inv);
    logic [DATA_W-1:0] d;
    logic [31:0]       b;
    b = 32'(a) ^ SEED;
    for (int k = 0; k < DATA_W/32; k++) d[k*32 +: 32] = b + 32'(k);
    return inv ? ~d : d;
  endfunction

  assign w_start    = (r_state == S_IDLE) && start_i;
  assign w_active   = (r_state == S_WR) || (r_state == S_WR_DRAIN) ||
                      (r_state == S_RD) || (r_state == S_RD_DRAIN);
  assign w_req      = ((r_state == S_WR) || (r_state == S_RD)) && (r_outst < MAX_O);
  assign w_acc      = w_req && mem_accept_i;
  assign w_last     = w_acc && (r_issued == r_count - 1'b1);
  assign w_ack      = mem_ack_i && w_active;
  assign w_stray    = w_ack && (r_outst == '0);
  assign w_pop      = w_ack && !w_stray && ((r_state == S_RD) || (r_state == S_RD_DRAIN));
  assign w_pop_addr = r_fifo[r_rptr];
  assign w_mis      = w_pop && (mem_rddata_i != gen_data(w_pop_addr, r_inv));

  // Error counter and first-error address for the coming cycle
  always_comb begin
    w_err_nxt   = r_err;
    w_first_nxt = r_first;
    if (w_start) begin
      w_err_nxt   = '0;
      w_first_nxt = '0;
    end else if (w_mis || w_stray) begin
      if (r_err != '1) w_err_nxt = r_err + 1'b1;
      if (w_mis && (r_err == '0)) w_first_nxt = w_pop_addr;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; a zero-length run goes straight to DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (start_i) begin
                    if (count_i == '0)        w_state_nxt = S_DONE;
                    else if (mode_i == 2'd2)  w_state_nxt = S_RD;
                    else                      w_state_nxt = S_WR;
                  end
      S_WR:       if (w_last) w_state_nxt = S_WR_DRAIN;
      S_WR_DRAIN: if (r_outst == '0) w_state_nxt = (r_mode == 2'd1) ? S_DONE : S_RD;
      S_RD:       if (w_last) w_state_nxt = S_RD_DRAIN;
      S_RD_DRAIN: if (r_outst == '0) w_state_nxt = S_DONE;
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs: request signals are zero whenever no request is presented
  always_comb begin
    busy_o       = (r_state != S_IDLE);
    done_o       = (r_state == S_DONE);
    mem_addr_o   = w_req ? r_addr : '0;
    mem_rd_o     = w_req && (r_state == S_RD);
    mem_wr_o     = (w_req && (r_state == S_WR)) ? '1 : '0;
    mem_wrdata_o = (w_req && (r_state == S_WR)) ? gen_data(r_addr, r_inv) : '0;
    pass_o           = r_pass;
    err_cnt_o        = r_err;
    first_err_addr_o = r_first;
  end

  // Run control: latch settings, step address, track outstanding and FIFO pointers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_mode   <= '0;
      r_inv    <= 1'b0;
      r_count  <= '0;
      r_addr   <= '0;
      r_issued <= '0;
      r_outst  <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_err    <= '0;
      r_first  <= '0;
      r_pass   <= 1'b0;
    end else begin
      r_err   <= w_err_nxt;
      r_first <= w_first_nxt;
      if (w_start) begin
        r_mode   <= mode_i;
        r_inv    <= invert_i;
        r_count  <= count_i;
        r_addr   <= base_addr_i;
        r_issued <= '0;
        r_wptr   <= '0;
        r_rptr   <= '0;
      end else if ((r_state == S_WR_DRAIN) && (w_state_nxt == S_RD)) begin
        r_addr   <= r_base;
        r_issued <= '0;
      end else if (w_acc) begin
        r_addr   <= r_addr + r_stride;
        r_issued <= r_issued + 1'b1;
        if (r_state == S_RD) r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_acc, w_ack && !w_stray})
        2'b10:   r_outst <= r_outst + 1'b1;
        2'b01:   r_outst <= r_outst - 1'b1;
        default: r_outst <= r_outst;
      endcase
      if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) r_pass <= (w_err_nxt == '0);
      else if (w_start)                                  r_pass <= 1'b0;
    end
  end

  // Run parameters and read-address FIFO storage
  always_ff @(posedge clk_i) begin
    if (w_start) begin
      r_base   <= base_addr_i;
      r_stride <= stride_i;
    end
    if (w_acc && (r_state == S_RD)) r_fifo[r_wptr] <= r_addr;
  end

endmodule
